// File: rtl/stump_control_unit.sv
// Stump control unit: IR/CC registers, fetch/execute/memory FSM, decode.
// Define STUMP_CTRL_TIMEOUT_EN to enable the sticky bus-timeout halt.
module stump_control_unit #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ready,
  input  logic [15:0] mem_rdata,
  input  logic [3:0]  flags,
  input  logic        run,
  input  logic        step,
  output logic [2:0]  state,
  output logic        fetch,
  output logic        execute,
  output logic        memory,
  output logic        halted,
  output logic [15:0] ir,
  output logic [3:0]  cc,
  output logic        ext_op,
  output logic        reg_write,
  output logic        opB_mux_sel,
  output logic        cc_en,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [2:0]  dest,
  output logic [2:0]  srcA,
  output logic [2:0]  srcB,
  output logic [1:0]  shift_op,
  output logic [2:0]  alu_func,
  output logic        bus_error
);

  typedef enum logic [2:0] {
    FETCH   = 3'b000,
    EXECUTE = 3'b001,
    MEMORY  = 3'b010,
    HALT    = 3'b011
  } state_t;

  localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TIMEOUT);
`ifdef STUMP_CTRL_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  state_t           st_q;
  state_t           st_n;
  logic [CNT_W-1:0] cnt_q;
  logic             step_q;
  logic             step_n;
  logic             waiting;
  logic             tmo_hit;
  logic             is_ldst;
  logic             is_bcc;
  logic             taken;
  logic             f_n, f_z, f_v, f_c;

  assign state   = st_q;
  assign fetch   = (st_q == FETCH);
  assign execute = (st_q == EXECUTE);
  assign memory  = (st_q == MEMORY);
  assign halted  = (st_q == HALT);

  assign is_ldst = (ir[15:13] == 3'b110);
  assign is_bcc  = (ir[15:13] == 3'b111);
  assign {f_n, f_z, f_v, f_c} = cc;

  assign waiting = fetch | memory;
  assign tmo_hit = TMO_EN & waiting & ~mem_ready
                 & (cnt_q >= TMO_LIM);

  // Branch condition evaluated on the registered flags
  always_comb begin
    taken = 1'b0;
    unique case (ir[11:8])
      4'd0:  taken = 1'b1;
      4'd1:  taken = 1'b0;
      4'd2:  taken = ~f_c & ~f_z;
      4'd3:  taken = f_c | f_z;
      4'd4:  taken = ~f_c;
      4'd5:  taken = f_c;
      4'd6:  taken = ~f_z;
      4'd7:  taken = f_z;
      4'd8:  taken = ~f_v;
      4'd9:  taken = f_v;
      4'd10: taken = ~f_n;
      4'd11: taken = f_n;
      4'd12: taken = (f_n == f_v);
      4'd13: taken = (f_n != f_v);
      4'd14: taken = ~f_z & (f_n == f_v);
      default: taken = f_z | (f_n != f_v);
    endcase
  end

  // Next state; instruction boundary halts when stopped or stepping
  always_comb begin
    st_n   = st_q;
    step_n = step_q;
    unique case (st_q)
      FETCH: begin
        if (tmo_hit) begin
          st_n   = HALT;
          step_n = 1'b0;
        end else if (mem_ready) begin
          st_n = EXECUTE;
        end
      end
      EXECUTE: begin
        if (is_ldst) begin
          st_n = MEMORY;
        end else if (!run || step_q) begin
          st_n   = HALT;
          step_n = 1'b0;
        end else begin
          st_n = FETCH;
        end
      end
      MEMORY: begin
        if (tmo_hit) begin
          st_n   = HALT;
          step_n = 1'b0;
        end else if (mem_ready) begin
          if (!run || step_q) begin
            st_n   = HALT;
            step_n = 1'b0;
          end else begin
            st_n = FETCH;
          end
        end
      end
      HALT: begin
        if (!bus_error) begin
          if (run) begin
            st_n = FETCH;
          end else if (step) begin
            st_n   = FETCH;
            step_n = 1'b1;
          end
        end
      end
      default: st_n = FETCH;
    endcase
  end

  // Datapath control decode from state, ir and cc
  always_comb begin
    ext_op      = 1'b0;
    reg_write   = 1'b0;
    opB_mux_sel = 1'b0;
    cc_en       = 1'b0;
    mem_ren     = 1'b0;
    mem_wen     = 1'b0;
    dest        = 3'd0;
    srcA        = 3'd0;
    srcB        = 3'd0;
    shift_op    = 2'd0;
    alu_func    = 3'd0;
    unique case (1'b1)
      fetch: begin
        mem_ren   = 1'b1;
        dest      = 3'd7;
        srcA      = 3'd7;
        reg_write = mem_ready;
      end
      execute: begin
        if (is_bcc) begin
          ext_op      = 1'b1;
          opB_mux_sel = 1'b1;
          dest        = 3'd7;
          srcA        = 3'd7;
          alu_func    = 3'b111;
          reg_write   = taken;
        end else begin
          dest      = ir[10:8];
          srcA      = ir[7:5];
          alu_func  = ir[15:13];
          cc_en     = ir[11] & ~is_ldst;
          reg_write = ~is_ldst;
          if (ir[12]) begin
            ext_op      = 1'b1;
            opB_mux_sel = 1'b1;
          end else begin
            srcB     = ir[4:2];
            shift_op = ir[1:0];
          end
        end
      end
      memory: begin
        mem_ren   = ~ir[11];
        mem_wen   = ir[11];
        dest      = ir[10:8];
        srcA      = ir[7:5];
        reg_write = ~ir[11] & mem_ready;
      end
      default: ;
    endcase
  end

  // State, IR, CC, wait counter and step/error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= FETCH;
      ir     <= 16'h0000;
      cc     <= 4'h0;
      cnt_q  <= '0;
      step_q <= 1'b0;
    end else begin
      st_q   <= st_n;
      step_q <= step_n;
      if (fetch && mem_ready) ir <= mem_rdata;
      if (cc_en) cc <= flags;
      if (st_n != st_q) cnt_q <= '0;
      else if (waiting && !mem_ready && cnt_q != '1)
        cnt_q <= cnt_q + 1'b1;
    end
  end

`ifdef STUMP_CTRL_TIMEOUT_EN
  // Sticky timeout flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) bus_error <= 1'b0;
    else if (tmo_hit) bus_error <= 1'b1;
  end
`else
  assign bus_error = 1'b0;
`endif

endmodule

// File: tb/tb_stump_control_unit.sv
// Directed self-checking bench for stump_control_unit.
// Expected values are hand-derived from the instruction encodings.
module tb_stump_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_ready;
  logic [15:0] mem_rdata;
  logic [3:0]  flags;
  logic        run;
  logic        step;
  logic [2:0]  state;
  logic        fetch, execute, memory, halted;
  logic [15:0] ir;
  logic [3:0]  cc;
  logic        ext_op, reg_write, opB_mux_sel, cc_en;
  logic        mem_ren, mem_wen;
  logic [2:0]  dest, srcA, srcB;
  logic [1:0]  shift_op;
  logic [2:0]  alu_func;
  logic        bus_error;

  int checks = 0;
  int errors = 0;

  stump_control_unit #(.TIMEOUT(3), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .flags(flags), .run(run),
    .step(step), .state(state), .fetch(fetch),
    .execute(execute), .memory(memory), .halted(halted),
    .ir(ir), .cc(cc), .ext_op(ext_op),
    .reg_write(reg_write), .opB_mux_sel(opB_mux_sel),
    .cc_en(cc_en), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .dest(dest), .srcA(srcA), .srcB(srcB),
    .shift_op(shift_op), .alu_func(alu_func),
    .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; mem_ready = 1'b1; mem_rdata = 16'h0A25;
    flags = 4'b0100; run = 1'b1; step = 1'b0;
    tick();
    chk("rst_state", 16'(state), 16'd0);
    chk("rst_fetch", 16'(fetch), 16'd1);
    chk("rst_mem_ren", 16'(mem_ren), 16'd1);
    chk("rst_ir", ir, 16'h0000);
    chk("rst_cc", 16'(cc), 16'h0);
    chk("rst_bus_error", 16'(bus_error), 16'd0);
    rst = 1'b0;
    settle();
    chk("f_reg_write", 16'(reg_write), 16'd1);
    chk("f_dest", 16'(dest), 16'd7);
    // register-form ADD with S=1
    tick();
    chk("alu_execute", 16'(execute), 16'd1);
    chk("alu_ir", ir, 16'h0A25);
    chk("alu_dest", 16'(dest), 16'd2);
    chk("alu_srcA", 16'(srcA), 16'd1);
    chk("alu_srcB", 16'(srcB), 16'd1);
    chk("alu_shift", 16'(shift_op), 16'd1);
    chk("alu_reg_write", 16'(reg_write), 16'd1);
    chk("alu_cc_en", 16'(cc_en), 16'd1);
    chk("alu_ext_op", 16'(ext_op), 16'd0);
    tick();
    chk("alu_back_fetch", 16'(fetch), 16'd1);
    chk("alu_cc", 16'(cc), 16'h4);
    // immediate form
    mem_rdata = 16'h1A25; flags = 4'b0001;
    tick();
    chk("imm_ext_op", 16'(ext_op), 16'd1);
    chk("imm_opB", 16'(opB_mux_sel), 16'd1);
    chk("imm_srcB", 16'(srcB), 16'd0);
    chk("imm_shift", 16'(shift_op), 16'd0);
    flags = 4'b0100;
    settle();
    tick();
    chk("imm_cc", 16'(cc), 16'h4);
    // LDST load with two wait cycles
    mem_rdata = 16'hC0E3;
    tick();
    chk("ld_ex_reg_write", 16'(reg_write), 16'd0);
    chk("ld_ex_cc_en", 16'(cc_en), 16'd0);
    mem_ready = 1'b0;
    settle();
    chk("ld_ex_ignore_rdy", 16'(execute), 16'd1);
    tick();
    chk("ld_m1_memory", 16'(memory), 16'd1);
    chk("ld_m1_ren", 16'(mem_ren), 16'd1);
    chk("ld_m1_wen", 16'(mem_wen), 16'd0);
    chk("ld_m1_reg_write", 16'(reg_write), 16'd0);
    tick();
    chk("ld_m2_memory", 16'(memory), 16'd1);
    chk("ld_m2_reg_write", 16'(reg_write), 16'd0);
    tick();
    mem_ready = 1'b1;
    settle();
    chk("ld_m3_memory", 16'(memory), 16'd1);
    chk("ld_m3_reg_write", 16'(reg_write), 16'd1);
    chk("ld_m3_dest", 16'(dest), 16'd0);
    chk("ld_m3_srcA", 16'(srcA), 16'd7);
    tick();
    chk("ld_done_fetch", 16'(fetch), 16'd1);
    chk("ld_cc_kept", 16'(cc), 16'h4);
    // BCC EQ taken with Z=1
    mem_rdata = 16'hE700;
    tick();
    chk("beq_t_reg_write", 16'(reg_write), 16'd1);
    chk("beq_t_dest", 16'(dest), 16'd7);
    chk("beq_t_alu", 16'(alu_func), 16'd7);
    chk("beq_t_ext_op", 16'(ext_op), 16'd1);
    chk("beq_t_cc_en", 16'(cc_en), 16'd0);
    // clear cc with ADD S=1, flags=0
    mem_rdata = 16'h0800; flags = 4'b0000;
    tick();
    tick();
    tick();
    chk("clr_cc", 16'(cc), 16'h0);
    mem_rdata = 16'hE700;
    tick();
    chk("beq_nt_reg_write", 16'(reg_write), 16'd0);
    chk("beq_nt_execute", 16'(execute), 16'd1);
    // run dropped during EXECUTE
    mem_rdata = 16'h0000;
    tick();
    tick();
    run = 1'b0;
    settle();
    tick();
    chk("halt_halted", 16'(halted), 16'd1);
    chk("halt_state", 16'(state), 16'd3);
    chk("halt_mem_ren", 16'(mem_ren), 16'd0);
    chk("halt_reg_write", 16'(reg_write), 16'd0);
    tick();
    chk("halt_stay", 16'(halted), 16'd1);
    // single step
    step = 1'b1;
    settle();
    tick();
    step = 1'b0;
    settle();
    chk("step_fetch", 16'(fetch), 16'd1);
    tick();
    chk("step_execute", 16'(execute), 16'd1);
    tick();
    chk("step_halted", 16'(halted), 16'd1);
    tick();
    chk("step_stay", 16'(halted), 16'd1);
    // resume, then stall FETCH
    run = 1'b1; mem_ready = 1'b0;
    settle();
    tick();
    chk("to_fetch", 16'(fetch), 16'd1);
    tick();
    tick();
    tick();
    chk("to_c3_fetch", 16'(fetch), 16'd1);
    tick();
`ifdef STUMP_CTRL_TIMEOUT_EN
    chk("to_halted", 16'(halted), 16'd1);
    chk("to_bus_error", 16'(bus_error), 16'd1);
    tick();
    chk("to_run_ignored", 16'(halted), 16'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk("to_rst_err", 16'(bus_error), 16'd0);
    chk("to_rst_fetch", 16'(fetch), 16'd1);
`else
    chk("nto_fetch", 16'(fetch), 16'd1);
    chk("nto_bus_error", 16'(bus_error), 16'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk("nto_rst_fetch", 16'(fetch), 16'd1);
`endif
    // reset inside a store wait
    mem_ready = 1'b1; mem_rdata = 16'h0800; flags = 4'b1010;
    tick();
    tick();
    chk("st_pre_cc", 16'(cc), 16'hA);
    mem_rdata = 16'hC800;
    tick();
    mem_ready = 1'b0;
    settle();
    tick();
    chk("st_memory", 16'(memory), 16'd1);
    chk("st_wen", 16'(mem_wen), 16'd1);
    chk("st_ren", 16'(mem_ren), 16'd0);
    chk("st_reg_write", 16'(reg_write), 16'd0);
    rst = 1'b1;
    tick();
    chk("st_rst_fetch", 16'(fetch), 16'd1);
    chk("st_rst_ir", ir, 16'h0000);
    chk("st_rst_cc", 16'(cc), 16'h0);
    chk("st_rst_wen", 16'(mem_wen), 16'd0);
    rst = 1'b0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
